// File: rtl/wm_cycle_controller.sv
// Washing-machine cycle controller: coins, fill/heat timeouts, rinse passes,
// fault retry and lockout. Optional prewash phase enabled by WM_PREWASH_EN.
module wm_cycle_controller #(
    parameter int COIN_PRICE   = 2,
    parameter int COIN_W       = 4,
    parameter int TIMER_W      = 16,
    parameter int FILL_TIMEOUT = 1000,
    parameter int HEAT_TIMEOUT = 2000,
    parameter int RINSE_COUNT  = 2,
    parameter int MAX_RETRIES  = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_Coin,
    input  logic sig_Cancel,
    input  logic sig_Lid_Closed,
    input  logic sig_Full,
    input  logic sig_Temperature,
    input  logic sig_Wash_Completed,
    input  logic sig_Rinse_Completed,
    input  logic sig_Spin_Completed,
    input  logic sig_Out_Of_Balance,
    input  logic sig_Motor_Failure,
`ifdef WM_PREWASH_EN
    input  logic sig_Prewash_Completed,
`endif
    input  logic fault_Ack,
    output logic [3:0] state,
    output logic [COIN_W-1:0] coins_held,
    output logic [$clog2(RINSE_COUNT+1)-1:0] rinse_index,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [2:0] fault_code,
    output logic water_Intake,
    output logic fault,
    output logic coin_Return,
    output logic done
);

    localparam int RI_W = $clog2(RINSE_COUNT + 1);
    localparam int RT_W = $clog2(MAX_RETRIES + 1);

    localparam logic [COIN_W-1:0]  PRICE      = COIN_W'(COIN_PRICE);
    localparam logic [TIMER_W-1:0] FILL_LIM   = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HEAT_LIM   = TIMER_W'(HEAT_TIMEOUT - 1);
    localparam logic [RI_W-1:0]    RINSE_LAST = RI_W'(RINSE_COUNT - 1);
    localparam logic [RT_W-1:0]    RETRY_MAX  = RT_W'(MAX_RETRIES);

    localparam logic [2:0] FC_NONE = 3'd0;
    localparam logic [2:0] FC_FILL = 3'd1;
    localparam logic [2:0] FC_HEAT = 3'd2;
    localparam logic [2:0] FC_OOB  = 3'd3;
    localparam logic [2:0] FC_MOT  = 3'd4;
    localparam logic [2:0] FC_LID  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_READY   = 4'd1,
        S_FILL    = 4'd2,
        S_HEAT    = 4'd3,
        S_WASH    = 4'd4,
        S_RINSE   = 4'd5,
        S_SPIN    = 4'd6,
        S_FAULT   = 4'd7,
        S_LOCKOUT = 4'd8,
        S_PREWASH = 4'd9
    } state_t;

`ifdef WM_PREWASH_EN
    localparam state_t HEAT_NEXT = S_PREWASH;
`else
    localparam state_t HEAT_NEXT = S_WASH;
`endif

    state_t state_q, state_d;
    logic [COIN_W-1:0]  coins_q, coins_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RI_W-1:0]    rinse_q, rinse_d;
    logic [RT_W-1:0]    retry_q, retry_d;
    logic [2:0]         code_q, code_d;
    logic               coin_q;
    logic               cret_q, cret_d;
    logic               done_q, done_d;
    logic               restart;
    logic               coin_rise;
    logic               running;

    // Edge-detect the coin input against its registered copy.
    assign coin_rise = sig_Coin & ~coin_q;

    // Phases in which an open lid aborts the cycle.
    assign running = (state_q == S_FILL)  || (state_q == S_HEAT) ||
                     (state_q == S_WASH)  || (state_q == S_RINSE) ||
                     (state_q == S_SPIN)  || (state_q == S_PREWASH);

    // State, counters and output pulses register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            coins_q <= '0;
            timer_q <= '0;
            rinse_q <= '0;
            retry_q <= '0;
            code_q  <= FC_NONE;
            coin_q  <= 1'b0;
            cret_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coins_q <= coins_d;
            timer_q <= timer_d;
            rinse_q <= rinse_d;
            retry_q <= retry_d;
            code_q  <= code_d;
            coin_q  <= sig_Coin;
            cret_q  <= cret_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter updates and pulse generation.
    always_comb begin
        state_d = state_q;
        coins_d = coins_q;
        rinse_d = rinse_q;
        retry_d = retry_q;
        code_d  = code_q;
        cret_d  = 1'b0;
        done_d  = 1'b0;
        restart = 1'b0;

        if (coin_rise && (coins_q != '1) &&
            ((state_q == S_IDLE) || (state_q == S_READY))) begin
            coins_d = coins_q + 1'b1;
        end

        if (running && !sig_Lid_Closed) begin
            state_d = S_FAULT;
            code_d  = FC_LID;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (coins_q >= PRICE) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (sig_Cancel) begin
                        state_d = S_IDLE;
                        cret_d  = 1'b1;
                        coins_d = '0;
                        retry_d = '0;
                        code_d  = FC_NONE;
                    end else if (sig_Lid_Closed) begin
                        state_d = S_FILL;
                        coins_d = '0;
                    end
                end
                S_FILL: begin
                    if (sig_Full) begin
                        state_d = S_HEAT;
                    end else if (timer_q == FILL_LIM) begin
                        state_d = S_FAULT;
                        code_d  = FC_FILL;
                    end
                end
                S_HEAT: begin
                    if (sig_Temperature) begin
                        state_d = HEAT_NEXT;
                    end else if (timer_q == HEAT_LIM) begin
                        state_d = S_FAULT;
                        code_d  = FC_HEAT;
                    end
                end
`ifdef WM_PREWASH_EN
                S_PREWASH: begin
                    if (sig_Prewash_Completed) begin
                        state_d = S_WASH;
                    end else if (sig_Out_Of_Balance) begin
                        state_d = S_FAULT;
                        code_d  = FC_OOB;
                    end
                end
`endif
                S_WASH: begin
                    if (sig_Wash_Completed) begin
                        state_d = S_RINSE;
                        rinse_d = '0;
                    end else if (sig_Out_Of_Balance) begin
                        state_d = S_FAULT;
                        code_d  = FC_OOB;
                    end
                end
                S_RINSE: begin
                    if (sig_Rinse_Completed) begin
                        if (rinse_q == RINSE_LAST) begin
                            state_d = S_SPIN;
                        end else begin
                            rinse_d = rinse_q + 1'b1;
                            restart = 1'b1;
                        end
                    end else if (sig_Motor_Failure) begin
                        state_d = S_FAULT;
                        code_d  = FC_MOT;
                    end
                end
                S_SPIN: begin
                    if (sig_Spin_Completed) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        retry_d = '0;
                        code_d  = FC_NONE;
                    end else if (sig_Motor_Failure) begin
                        state_d = S_FAULT;
                        code_d  = FC_MOT;
                    end else if (sig_Out_Of_Balance) begin
                        state_d = S_FAULT;
                        code_d  = FC_OOB;
                    end
                end
                S_FAULT: begin
                    if (fault_Ack) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_LOCKOUT;
                        end else begin
                            state_d = S_READY;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                S_LOCKOUT: begin
                    state_d = S_LOCKOUT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if ((state_d != state_q) || restart) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    assign state        = state_q;
    assign coins_held   = coins_q;
    assign rinse_index  = rinse_q;
    assign retry_count  = retry_q;
    assign fault_code   = code_q;
    assign water_Intake = (state_q == S_FILL) || (state_q == S_RINSE);
    assign fault        = (state_q == S_FAULT) || (state_q == S_LOCKOUT);
    assign coin_Return  = cret_q;
    assign done         = done_q;

endmodule
